// File: rtl/sssp_update_packer_pkg.sv
// Shared types for the SSSP update packer: update word, packed line, pad word and FSM states.
package sssp_update_packer_pkg;

  localparam int UPD_PER_LINE = 8;
  localparam int UPD_W        = 64;
  localparam int LINE_W       = UPD_PER_LINE * UPD_W;

  typedef struct packed {
    logic [31:0] weight;
    logic [31:0] dst;
  } update_t;

  typedef update_t [UPD_PER_LINE-1:0] line_t;

  localparam update_t PAD_UPDATE = '{weight: 32'hFFFF_FFFF, dst: 32'hFFFF_FFFF};

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    DRAIN
  } packer_state_e;

endpackage

// File: rtl/sssp_update_packer_fifo.sv
// Synchronous first-word-fall-through line FIFO; a push into a full FIFO only lands if a pop frees a slot.
module update_line_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sssp_update_packer.sv
// Packs per-lane SSSP updates into 8-slot 512-bit lines and queues them for the write path.
// Optional SSSP_UPD_STATS_EN adds saturating accepted-update and popped-line counters.
module sssp_update_packer
  import sssp_update_packer_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_LANES-1:0]             upd_valid,
  input  logic [NUM_LANES-1:0][UPD_W-1:0]  upd_data,
  input  logic                             last_in,
  output logic [LINE_W-1:0]                line_out,
  output logic                             line_valid,
  input  logic                             line_ready,
  output logic                             almost_full,
  output logic                             pass_done,
  output logic                             overflow_err
`ifdef SSSP_UPD_STATS_EN
  ,
  output logic [31:0]                      stat_updates,
  output logic [31:0]                      stat_lines
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] AFULL_LVL = CW'(FIFO_DEPTH - AFULL_MARGIN);

  packer_state_e    state, state_n;
  logic [2:0]       fill_p1;
  line_t            line_p1;

  logic             acc_p0;
  logic [3:0]       pos;
  logic [3:0]       k_p0;
  line_t            line_nxt_p0;
  line_t            cmpl_line_p0;
  line_t            flush_line_p0;
  logic             cmpl_vld_p0;
  logic             flush_vld_p0;
  logic             push_vld_p0;
  line_t            push_line_p0;
  logic             late_upd_p0;

  logic [LINE_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              pop_ok;
  logic              wr_ok;
  logic [CW-1:0]     cnt_nxt;

  // Stage 0: compaction of valid lanes into the open line; wrapped lanes seed the next line
  always_comb begin
    acc_p0       = (state == ACCUM);
    line_nxt_p0  = line_p1;
    cmpl_line_p0 = line_p1;
    k_p0         = '0;
    pos          = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      pos = {1'b0, fill_p1} + k_p0;
      if (upd_valid[j]) begin
        line_nxt_p0[pos[2:0]] = upd_data[j];
        if (!pos[3]) cmpl_line_p0[pos[2:0]] = upd_data[j];
        k_p0 = k_p0 + 4'd1;
      end
    end
    for (int i = 0; i < UPD_PER_LINE; i++) begin
      flush_line_p0[i] = (3'(i) < fill_p1) ? line_p1[i] : PAD_UPDATE;
    end
    cmpl_vld_p0  = acc_p0 && (({1'b0, fill_p1} + k_p0) >= 4'd8);
    flush_vld_p0 = (state == FLUSH) && (fill_p1 != '0);
    push_vld_p0  = cmpl_vld_p0 | flush_vld_p0;
    push_line_p0 = flush_vld_p0 ? flush_line_p0 : cmpl_line_p0;
    late_upd_p0  = ~acc_p0 & (|upd_valid);
  end

  assign pop_ok  = line_ready & ~fifo_empty;
  assign wr_ok   = push_vld_p0 & (~fifo_full | pop_ok);
  assign cnt_nxt = fifo_count + CW'(wr_ok) - CW'(pop_ok);

  always_comb begin
    state_n   = state;
    pass_done = 1'b0;
    unique case (state)
      ACCUM: if (last_in) state_n = FLUSH;
      FLUSH: state_n = DRAIN;
      DRAIN: begin
        if (fifo_empty) begin
          state_n   = ACCUM;
          pass_done = ~rst;
        end
      end
      default: state_n = ACCUM;
    endcase
  end

  // Stage 1: open-line register, fill counter and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      fill_p1      <= '0;
      overflow_err <= 1'b0;
      almost_full  <= 1'b0;
    end else begin
      state <= state_n;
      if (acc_p0)              fill_p1 <= fill_p1 + k_p0[2:0];
      else if (state == FLUSH) fill_p1 <= '0;
      if ((push_vld_p0 & ~wr_ok) | late_upd_p0) overflow_err <= 1'b1;
      almost_full <= (cnt_nxt >= AFULL_LVL);
    end
  end

  always_ff @(posedge clk) begin
    if (acc_p0) line_p1 <= line_nxt_p0;
  end

  update_line_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_vld_p0),
    .din   (push_line_p0),
    .pop   (line_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign line_valid = ~fifo_empty;
  assign line_out   = line_valid ? fifo_dout : '0;

`ifdef SSSP_UPD_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_updates <= '0;
      stat_lines   <= '0;
    end else begin
      if (acc_p0) stat_updates <= sat_add(stat_updates, 32'(k_p0));
      if (pop_ok) stat_lines   <= sat_add(stat_lines, 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_sssp_update_packer.sv
// Bench for sssp_update_packer: directed scenarios plus random traffic against a queue-based reference.
module tb_sssp_update_packer;
  import sssp_update_packer_pkg::*;

  localparam int DEPTH = 16;
  localparam int MARGIN = 3;
  localparam logic [63:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        upd_valid;
  logic [3:0][63:0]  upd_data;
  logic              last_in;
  logic [511:0]      line_out;
  logic              line_valid;
  logic              line_ready;
  logic              almost_full;
  logic              pass_done;
  logic              overflow_err;

  always #5 clk = ~clk;

  sssp_update_packer #(
    .NUM_LANES    (4),
    .FIFO_DEPTH   (DEPTH),
    .AFULL_MARGIN (MARGIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .upd_valid    (upd_valid),
    .upd_data     (upd_data),
    .last_in      (last_in),
    .line_out     (line_out),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .almost_full  (almost_full),
    .pass_done    (pass_done),
    .overflow_err (overflow_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference: updates of the open line, queue of lines held for the consumer, pass phase.
  logic [63:0]  pend[$];
  logic [511:0] mq[$];
  logic [511:0] popped[$];
  int           phase = 0;   // 0 accept, 1 flush, 2 drain
  bit           m_ovf = 0;
  bit           m_afull = 0;

  task automatic model_step();
    bit pop;
    bit push;
    logic [511:0] pl;
    pl = '0;
    push = 0;
    if (rst) begin
      pend.delete();
      mq.delete();
      phase = 0;
      m_ovf = 0;
      m_afull = 0;
      return;
    end
    pop = line_ready && (mq.size() > 0);
    case (phase)
      0: begin
        for (int j = 0; j < 4; j++) if (upd_valid[j]) pend.push_back(upd_data[j]);
        if (pend.size() >= 8) begin
          for (int i = 0; i < 8; i++) pl[64*i +: 64] = pend.pop_front();
          push = 1;
        end
        if (last_in) phase = 1;
      end
      1: begin
        if (upd_valid != 0) m_ovf = 1;
        if (pend.size() > 0) begin
          for (int i = 0; i < 8; i++) pl[64*i +: 64] = (pend.size() > 0) ? pend.pop_front() : PAD;
          push = 1;
        end
        phase = 2;
      end
      default: begin
        if (upd_valid != 0) m_ovf = 1;
        if (mq.size() == 0) phase = 0;
      end
    endcase
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(pl);
      else m_ovf = 1;
    end
    m_afull = (DEPTH - mq.size()) <= MARGIN;
  endtask

  task automatic tick();
    check("line_valid", line_valid, mq.size() > 0);
    check("line_out", line_out, (mq.size() > 0) ? mq[0] : 512'd0);
    check("almost_full", almost_full, m_afull);
    check("pass_done", pass_done, !rst && phase == 2 && mq.size() == 0);
    check("overflow_err", overflow_err, m_ovf);
    if (line_valid && line_ready) popped.push_back(line_out);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    upd_valid = '0;
    last_in   = 1'b0;
  endtask

  logic [511:0] exp;
  bit           seen;

  initial begin
    rst = 1'b1;
    upd_valid = '0;
    upd_data = '0;
    last_in = 1'b0;
    line_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check("rst_line_valid", line_valid, 1'b0);
    check("rst_almost_full", almost_full, 1'b0);
    check("rst_pass_done", pass_done, 1'b0);
    check("rst_overflow", overflow_err, 1'b0);

    // Lane 0 only, eight updates -> one line visible the cycle after the 8th
    for (int i = 0; i < 8; i++) begin
      upd_valid = 4'b0001;
      upd_data[0] = {32'(10 * i), 32'(i)};
      tick();
    end
    idle();
    check("s1_valid_next_cycle", line_valid, 1'b1);
    for (int i = 0; i < 8; i++) exp[64*i +: 64] = {32'(10 * i), 32'(i)};
    check("s1_line", line_out, exp);
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    check("s1_popped_empty", line_valid, 1'b0);

    // Four lanes for three cycles, then end of pass with a padded partial line
    popped.delete();
    line_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      upd_valid = 4'hF;
      for (int j = 0; j < 4; j++) upd_data[j] = {32'(100 + 4 * c + j), 32'(4 * c + j)};
      tick();
    end
    idle();
    last_in = 1'b1;
    tick();
    last_in = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (pass_done) seen = 1;
      tick();
    end
    check("s2_pass_done_seen", seen, 1'b1);
    check("s2_two_lines", popped.size(), 2);
    for (int i = 0; i < 8; i++) exp[64*i +: 64] = {32'(100 + i), 32'(i)};
    check("s2_line1", (popped.size() > 0) ? popped[0] : 512'd0, exp);
    for (int i = 0; i < 8; i++) exp[64*i +: 64] = (i < 4) ? {32'(108 + i), 32'(8 + i)} : PAD;
    check("s2_line2_padded", (popped.size() > 1) ? popped[1] : 512'd0, exp);
    line_ready = 1'b0;

    // Fill 7, then lanes 1 and 3: lane 1 completes the line, lane 3 opens the next
    for (int i = 0; i < 7; i++) begin
      upd_valid = 4'b0001;
      upd_data[0] = {32'(200 + i), 32'(i)};
      tick();
    end
    upd_valid = 4'b1010;
    upd_data[0] = 64'hDEAD_0000_DEAD_0000;
    upd_data[1] = {32'd301, 32'd71};
    upd_data[2] = 64'hDEAD_0002_DEAD_0002;
    upd_data[3] = {32'd303, 32'd73};
    tick();
    idle();
    for (int i = 0; i < 7; i++) exp[64*i +: 64] = {32'(200 + i), 32'(i)};
    exp[64*7 +: 64] = {32'd301, 32'd71};
    check("s3_lane1_slot7", line_out, exp);
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    for (int i = 1; i < 8; i++) begin
      upd_valid = 4'b0001;
      upd_data[0] = {32'(400 + i), 32'(i)};
      tick();
    end
    idle();
    exp[63:0] = {32'd303, 32'd73};
    for (int i = 1; i < 8; i++) exp[64*i +: 64] = {32'(400 + i), 32'(i)};
    check("s3_lane3_slot0", line_out, exp);
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;

    // Seventeen lines with no consumer: almost_full then a dropped line
    for (int c = 0; c < 34; c++) begin
      upd_valid = 4'hF;
      for (int j = 0; j < 4; j++) upd_data[j] = {$urandom, $urandom};
      tick();
    end
    idle();
    check("s4_almost_full", almost_full, 1'b1);
    check("s4_overflow_sticky", overflow_err, 1'b1);
    tick();
    check("s4_overflow_held", overflow_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // End of pass with nothing open: done two cycles after last_in
    last_in = 1'b1;
    tick();
    last_in = 1'b0;
    tick();
    check("s5_pass_done", pass_done, 1'b1);
    check("s5_no_pad_line", line_valid, 1'b0);
    tick();

    // Reset mid-pass with two lines queued and five updates open
    for (int c = 0; c < 5; c++) begin
      upd_valid = 4'hF;
      for (int j = 0; j < 4; j++) upd_data[j] = {$urandom, $urandom};
      tick();
    end
    upd_valid = 4'b0001;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_flushed_by_rst", line_valid, 1'b0);
    check("s6_no_pass_done", pass_done, 1'b0);
    for (int i = 0; i < 8; i++) begin
      upd_valid = 4'b0001;
      upd_data[0] = {32'(500 + i), 32'(i)};
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) exp[64*i +: 64] = {32'(500 + i), 32'(i)};
    check("s6_new_pass_slot0", line_out, exp);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 499) == 0);
      upd_valid  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      for (int j = 0; j < 4; j++) upd_data[j] = {$urandom, $urandom};
      last_in    = ($urandom_range(0, 39) == 0);
      line_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
